// File: rtl/pio_bank_pkg.sv
// Shared constants for the Avalon-MM PIO bank: register map, INFO version
// and debounce history depth.
package pio_bank_pkg;

  localparam logic [3:0] ADDR_IN_DATA   = 4'd0;
  localparam logic [3:0] ADDR_EDGE_CAP  = 4'd1;
  localparam logic [3:0] ADDR_IRQ_MASK  = 4'd2;
  localparam logic [3:0] ADDR_EDGE_MODE = 4'd3;
  localparam logic [3:0] ADDR_DEB_EN    = 4'd4;
  localparam logic [3:0] ADDR_INFO      = 4'd5;
  localparam logic [3:0] ADDR_OUT_BASE  = 4'd8;

  localparam logic [15:0] INFO_VERSION = 16'h0100;

  localparam int DEB_HIST_DEPTH = 3;

endpackage

// File: rtl/pio_input_conditioner.sv
// Input path of the PIO bank: synchroniser, debounce prescaler, per-bit
// debounce history, post-reset priming and per-bit edge detection.
module pio_input_conditioner
  import pio_bank_pkg::*;
#(
  parameter int IN_W            = 32,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] in_port,
  input  logic [IN_W-1:0] deb_en,
  input  logic [IN_W-1:0] edge_mode,
  output logic [IN_W-1:0] deb_value,
  output logic [IN_W-1:0] det
);

  localparam int                 PRESC_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]         PRIME_LAST = 3'(SYNC_STAGES + 2);

  logic [IN_W-1:0]    sync_chain_r [SYNC_STAGES];
  logic [IN_W-1:0]    sync_s;
  logic [PRESC_W-1:0] presc_r;
  logic               tick_s;
  logic [IN_W-1:0]    hist_r [DEB_HIST_DEPTH];
  logic [IN_W-1:0]    hist_eq_s;
  logic [IN_W-1:0]    deb_next_s;
  logic [IN_W-1:0]    det_next_s;
  logic [IN_W-1:0]    deb_r;
  logic [IN_W-1:0]    det_r;
  logic [2:0]         prime_cnt_r;
  logic               primed_r;

  assign sync_s    = sync_chain_r[SYNC_STAGES-1];
  assign tick_s    = (presc_r == PRESC_LAST);
  assign deb_value = deb_r;
  assign det       = det_r;

  // Metastability chain for the asynchronous board inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_chain_r[s] <= '0;
    end else begin
      sync_chain_r[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_chain_r[s] <= sync_chain_r[s-1];
    end
  end

  // Debounce sample prescaler, wrapping at DEBOUNCE_CYCLES-1
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRESC_W'(1);
    end
  end

  // Priming timer: covers the synchroniser fill after reset release
  always_ff @(posedge clk) begin
    if (reset) begin
      prime_cnt_r <= 3'd0;
      primed_r    <= 1'b0;
    end else if (!primed_r) begin
      prime_cnt_r <= prime_cnt_r + 3'd1;
      if (prime_cnt_r == PRIME_LAST) primed_r <= 1'b1;
    end
  end

  // Debounce history; preloaded while unprimed so held inputs start settled
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < DEB_HIST_DEPTH; d++) hist_r[d] <= '0;
    end else if (!primed_r) begin
      for (int d = 0; d < DEB_HIST_DEPTH; d++) hist_r[d] <= sync_s;
    end else if (tick_s) begin
      hist_r[0] <= sync_s;
      for (int d = 1; d < DEB_HIST_DEPTH; d++) hist_r[d] <= hist_r[d-1];
    end
  end

  // Next debounced value and the edge it produces
  always_comb begin
    hist_eq_s = '1;
    for (int d = 1; d < DEB_HIST_DEPTH; d++) hist_eq_s = hist_eq_s & ~(hist_r[d] ^ hist_r[0]);
    if (!primed_r) begin
      deb_next_s = sync_s;
      det_next_s = '0;
    end else begin
      deb_next_s = (~deb_en & sync_s)
                 | (deb_en & hist_eq_s & hist_r[0])
                 | (deb_en & ~hist_eq_s & deb_r);
      det_next_s = (~edge_mode & ~deb_r & deb_next_s)
                 | (edge_mode & deb_r & ~deb_next_s);
    end
  end

  // Debounced value and one-cycle detect pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_r <= '0;
      det_r <= '0;
    end else begin
      deb_r <= deb_next_s;
      det_r <= det_next_s;
    end
  end

endmodule

// File: rtl/avalon_pio_bank.sv
// Avalon-MM PIO bank: N_OUT output channels, conditioned input port with
// edge capture, interrupt mask and one level interrupt.
module avalon_pio_bank
  import pio_bank_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int N_OUT           = 4,
  parameter int IN_W            = 32,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [DATA_W-1:0]       avs_writedata,
  output logic [DATA_W-1:0]       avs_readdata,
  output logic                    irq,
  input  logic [IN_W-1:0]         in_port,
  output logic [N_OUT*DATA_W-1:0] out_port
);

  localparam logic [31:0] INFO_FULL = {8'(N_OUT), 8'(IN_W), INFO_VERSION};

  logic [IN_W-1:0]   edge_cap_r;
  logic [IN_W-1:0]   irq_mask_r;
  logic [IN_W-1:0]   edge_mode_r;
  logic [IN_W-1:0]   deb_en_r;
  logic [DATA_W-1:0] out_r [N_OUT];
  logic [DATA_W-1:0] readdata_r;
  logic              irq_r;

  logic [IN_W-1:0]   deb_s;
  logic [IN_W-1:0]   det_s;
  logic [IN_W-1:0]   wdata_in_s;
  logic [IN_W-1:0]   edge_cap_next_s;
  logic              wr_edge_cap_s;
  logic              wr_irq_mask_s;
  logic              wr_edge_mode_s;
  logic              wr_deb_en_s;
  logic              out_hit_s;
  logic [2:0]        out_idx_s;
  logic [DATA_W-1:0] rd_out_s;
  logic [DATA_W-1:0] rd_mux_s;

  pio_input_conditioner #(
    .IN_W            (IN_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_cond (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .deb_en    (deb_en_r),
    .edge_mode (edge_mode_r),
    .deb_value (deb_s),
    .det       (det_s)
  );

  assign wdata_in_s     = avs_writedata[IN_W-1:0];
  assign wr_edge_cap_s  = avs_write && (avs_address == ADDR_EDGE_CAP);
  assign wr_irq_mask_s  = avs_write && (avs_address == ADDR_IRQ_MASK);
  assign wr_edge_mode_s = avs_write && (avs_address == ADDR_EDGE_MODE);
  assign wr_deb_en_s    = avs_write && (avs_address == ADDR_DEB_EN);
  assign out_idx_s      = avs_address[2:0];
  assign out_hit_s      = avs_address[3] && ({1'b0, avs_address[2:0]} < 4'(N_OUT));

  assign avs_readdata = readdata_r;
  assign irq          = irq_r;

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign out_port[k*DATA_W +: DATA_W] = out_r[k];
  end

  // Edge capture update: a detect in the same cycle as W1C keeps the bit set
  always_comb begin
    edge_cap_next_s = edge_cap_r;
    if (wr_edge_cap_s) begin
      edge_cap_next_s = (edge_cap_r & ~wdata_in_s) | det_s;
    end else begin
      edge_cap_next_s = edge_cap_r | det_s;
    end
  end

  // Read data selection
  always_comb begin
    rd_out_s = '0;
    for (int k = 0; k < N_OUT; k++) begin
      rd_out_s = rd_out_s | ((out_hit_s && (out_idx_s == 3'(k))) ? out_r[k] : '0);
    end
    case (avs_address)
      ADDR_IN_DATA:   rd_mux_s = DATA_W'(deb_s);
      ADDR_EDGE_CAP:  rd_mux_s = DATA_W'(edge_cap_r);
      ADDR_IRQ_MASK:  rd_mux_s = DATA_W'(irq_mask_r);
      ADDR_EDGE_MODE: rd_mux_s = DATA_W'(edge_mode_r);
      ADDR_DEB_EN:    rd_mux_s = DATA_W'(deb_en_r);
      ADDR_INFO:      rd_mux_s = INFO_FULL[DATA_W-1:0];
      default:        rd_mux_s = rd_out_s;
    endcase
  end

  // Control/status registers and output channels
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cap_r  <= '0;
      irq_mask_r  <= '0;
      edge_mode_r <= '0;
      deb_en_r    <= '1;
      for (int k = 0; k < N_OUT; k++) out_r[k] <= '0;
    end else begin
      edge_cap_r <= edge_cap_next_s;
      if (wr_irq_mask_s)  irq_mask_r  <= wdata_in_s;
      if (wr_edge_mode_s) edge_mode_r <= wdata_in_s;
      if (wr_deb_en_s)    deb_en_r    <= wdata_in_s;
      for (int k = 0; k < N_OUT; k++) begin
        if (avs_write && (avs_address == ADDR_OUT_BASE + 4'(k))) out_r[k] <= avs_writedata;
      end
    end
  end

  // Registered read data (latency 1, holds when idle) and level interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_r <= '0;
      irq_r      <= 1'b0;
    end else begin
      if (avs_read) readdata_r <= rd_mux_s;
      irq_r <= |(edge_cap_r & irq_mask_r);
    end
  end

endmodule

// File: tb/tb_avalon_pio_bank.sv
// Directed self-checking bench for avalon_pio_bank (DEBOUNCE_CYCLES=4,
// N_OUT=4, IN_W=8, DATA_W=32).
module tb_avalon_pio_bank;

  localparam int DATA_W = 32;
  localparam int N_OUT  = 4;
  localparam int IN_W   = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [3:0]              avs_address;
  logic                    avs_read;
  logic                    avs_write;
  logic [DATA_W-1:0]       avs_writedata;
  logic [DATA_W-1:0]       avs_readdata;
  logic                    irq;
  logic [IN_W-1:0]         in_port;
  logic [N_OUT*DATA_W-1:0] out_port;

  int n_checks = 0;
  int n_pass   = 0;

  avalon_pio_bank #(
    .DATA_W          (DATA_W),
    .N_OUT           (N_OUT),
    .IN_W            (IN_W),
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .in_port       (in_port),
    .out_port      (out_port)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    step();
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    step();
    avs_read    = 1'b0;
    d           = avs_readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_d;
    bit          irq_seen;
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (avs_readdata !== 32'h0) $display("FAIL reset_readdata got=%h exp=%h", avs_readdata, 32'h0); else n_pass++;
    n_checks++; if (out_port !== 128'h0) $display("FAIL reset_out_port got=%h exp=0", out_port); else n_pass++;
    reset = 1'b0;
    step();
    irq_seen = 1'b0;
    for (int a = 0; a < 16; a++) begin
      exp_d = 32'h0;
      if (a == 4) exp_d = 32'h0000_00FF;
      if (a == 5) exp_d = 32'h0408_0100;
      bus_read(4'(a), d);
      if (irq !== 1'b0) irq_seen = 1'b1;
      n_checks++; if (d !== exp_d) $display("FAIL reset_map addr=%0d got=%h exp=%h", a, d, exp_d); else n_pass++;
    end
    n_checks++; if (irq_seen) $display("FAIL reset_irq got=1 exp=0"); else n_pass++;
  endtask

  task automatic test_write_read();
    logic [31:0] d;
    bus_write(4'd10, 32'hDEAD_BEEF);
    n_checks++; if (out_port[95:64] !== 32'hDEAD_BEEF) $display("FAIL out2_port got=%h exp=%h", out_port[95:64], 32'hDEAD_BEEF); else n_pass++;
    n_checks++; if ({out_port[127:96], out_port[63:0]} !== 96'h0) $display("FAIL other_channels got=%h exp=0", {out_port[127:96], out_port[63:0]}); else n_pass++;
    bus_read(4'd10, d);
    n_checks++; if (d !== 32'hDEAD_BEEF) $display("FAIL out2_readback got=%h exp=%h", d, 32'hDEAD_BEEF); else n_pass++;
    step();
    n_checks++; if (avs_readdata !== 32'hDEAD_BEEF) $display("FAIL readdata_hold got=%h exp=%h", avs_readdata, 32'hDEAD_BEEF); else n_pass++;
    bus_write(4'd7, 32'hFFFF_FFFF);
    bus_read(4'd7, d);
    n_checks++; if (d !== 32'h0) $display("FAIL unmapped_rd got=%h exp=0", d); else n_pass++;
    bus_write(4'd3, 32'hFFFF_FF00);
    bus_read(4'd3, d);
    n_checks++; if (d !== 32'h0) $display("FAIL mode_upper_bits got=%h exp=0", d); else n_pass++;
    bus_write(4'd12, 32'h1234_5678);
    bus_read(4'd12, d);
    n_checks++; if (d !== 32'h0) $display("FAIL out_beyond_n got=%h exp=0", d); else n_pass++;
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    bit          glitch_seen;
    int          rise_at;
    bus_write(4'd4, 32'h01);
    glitch_seen = 1'b0;
    in_port[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_read(4'd0, d);
      if (d[0]) glitch_seen = 1'b1;
    end
    in_port[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus_read(4'd0, d);
      if (d[0]) glitch_seen = 1'b1;
    end
    n_checks++; if (glitch_seen) $display("FAIL glitch_passed got=1 exp=0"); else n_pass++;
    bus_read(4'd1, d);
    n_checks++; if (d !== 32'h0) $display("FAIL glitch_edge got=%h exp=0", d); else n_pass++;
    in_port[0] = 1'b1;
    rise_at = -1;
    for (int i = 0; i < 30; i++) begin
      bus_read(4'd0, d);
      if (d[0] && rise_at < 0) rise_at = i;
    end
    n_checks++; if (rise_at < 10 || rise_at > 18) $display("FAIL deb_rise_cycle got=%0d exp=10..18", rise_at); else n_pass++;
    bus_read(4'd1, d);
    n_checks++; if (d !== 32'h01) $display("FAIL deb_edge_cap got=%h exp=%h", d, 32'h01); else n_pass++;
    bus_write(4'd1, 32'h01);
    repeat (20) step();
    bus_read(4'd1, d);
    n_checks++; if (d !== 32'h0) $display("FAIL deb_edge_once got=%h exp=0", d); else n_pass++;
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    bus_write(4'd2, 32'h02);
    bus_write(4'd3, 32'h02);
    bus_write(4'd4, 32'h00);
    in_port[1] = 1'b1;
    repeat (8) step();
    bus_read(4'd1, d);
    n_checks++; if (d !== 32'h0 || irq !== 1'b0) $display("FAIL rise_ignored cap=%h irq=%b exp cap=0 irq=0", d, irq); else n_pass++;
    in_port[1] = 1'b0;
    repeat (4) step();
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_early got=%b exp=0", irq); else n_pass++;
    step();
    n_checks++; if (irq !== 1'b1) $display("FAIL irq_rise got=%b exp=1", irq); else n_pass++;
    bus_read(4'd1, d);
    n_checks++; if (d !== 32'h02) $display("FAIL fall_cap got=%h exp=%h", d, 32'h02); else n_pass++;
    bus_write(4'd1, 32'h02);
    n_checks++; if (irq !== 1'b1) $display("FAIL irq_hold_clr got=%b exp=1", irq); else n_pass++;
    step();
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_drop got=%b exp=0", irq); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bus_write(4'd2, 32'h08);
    bus_write(4'd3, 32'h00);
    in_port[3] = 1'b1;
    repeat (6) step();
    n_checks++; if (irq !== 1'b1) $display("FAIL b3_first_irq got=%b exp=1", irq); else n_pass++;
    in_port[3] = 1'b0;
    repeat (6) step();
    in_port[3] = 1'b1;
    repeat (3) step();
    bus_write(4'd1, 32'h08);
    step();
    n_checks++; if (irq !== 1'b1) $display("FAIL collide_irq got=%b exp=1", irq); else n_pass++;
    bus_read(4'd1, d);
    n_checks++; if (d !== 32'h08) $display("FAIL collide_cap got=%h exp=%h", d, 32'h08); else n_pass++;
    bus_write(4'd1, 32'h08);
    step();
    n_checks++; if (irq !== 1'b0) $display("FAIL plain_clr_irq got=%b exp=0", irq); else n_pass++;
  endtask

  task automatic test_prime_and_reset();
    logic [31:0] d;
    in_port = 8'hFF;
    reset   = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (20) step();
    bus_read(4'd0, d);
    n_checks++; if (d !== 32'hFF) $display("FAIL primed_in_data got=%h exp=%h", d, 32'hFF); else n_pass++;
    bus_read(4'd1, d);
    n_checks++; if (d !== 32'h0 || irq !== 1'b0) $display("FAIL primed_no_edge cap=%h irq=%b exp cap=0 irq=0", d, irq); else n_pass++;
    bus_write(4'd8, 32'hA5A5_A5A5);
    bus_write(4'd2, 32'hFF);
    n_checks++; if (out_port[31:0] !== 32'hA5A5_A5A5) $display("FAIL pre_reset_out0 got=%h exp=%h", out_port[31:0], 32'hA5A5_A5A5); else n_pass++;
    avs_address = 4'd0;
    avs_read    = 1'b1;
    reset       = 1'b1;
    step();
    avs_read = 1'b0;
    n_checks++; if (avs_readdata !== 32'h0) $display("FAIL midread_readdata got=%h exp=0", avs_readdata); else n_pass++;
    n_checks++; if (out_port !== 128'h0) $display("FAIL midread_out_port got=%h exp=0", out_port); else n_pass++;
    step();
    reset = 1'b0;
    repeat (10) step();
    bus_read(4'd2, d);
    n_checks++; if (d !== 32'h0) $display("FAIL post_mask got=%h exp=0", d); else n_pass++;
    bus_read(4'd4, d);
    n_checks++; if (d !== 32'hFF) $display("FAIL post_deb_en got=%h exp=%h", d, 32'hFF); else n_pass++;
    bus_read(4'd8, d);
    n_checks++; if (d !== 32'h0) $display("FAIL post_out0 got=%h exp=0", d); else n_pass++;
    bus_read(4'd0, d);
    n_checks++; if (d !== 32'hFF || irq !== 1'b0) $display("FAIL post_in_irq in=%h irq=%b exp in=ff irq=0", d, irq); else n_pass++;
  endtask

  initial begin
    reset         = 1'b1;
    avs_address   = 4'd0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = 32'h0;
    in_port       = 8'h00;
    test_reset();
    test_write_read();
    test_debounce();
    test_edge_irq();
    test_back_to_back();
    test_prime_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
